tank_sprite_arbiter: RTL and testbench
======================================

Name: tank_sprite_arbiter

Overview:
- Shares one four-direction tank image ROM bank between two tanks (tank 0, tank 1) on the VGA pixel stream.
- Generates the shared 12-bit ROM address and picks the direction image; up, down, right and left ROM outputs all receive the same address.
- Composites the selected sprite pixel over the incoming background and delays the timing signals to match.
- Sits between the background drawer and the VGA output stage.

Parameters:
SPRITE_BITS, 6, log2 of sprite edge; sprite is 64x64; ROM address = 2*SPRITE_BITS bits
TRANSPARENT_RGB, 12'hFFF, ROM colour treated as see-through
COORD_W, 11, width of hcount/vcount and tank coordinates

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hcount_in, vcount_in  in  COORD_W  current pixel coordinates
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing from upstream
rgb_in  in  12  background pixel
tank0_x, tank0_y, tank1_x, tank1_y  in  COORD_W  sprite top-left corners
tank0_dir, tank1_dir  in  2  0=up, 1=down, 2=right, 3=left
tank_en  in  2  per-tank draw enable (bit0 = tank 0)
rom_address  out  12  shared address to all four image ROMs
rom_rgb0..rom_rgb3  in  12 each  ROM data; 0=up, 1=down, 2=right, 3=left; synchronous, 1-cycle read
hcount_out, vcount_out  out  COORD_W  delayed coordinates
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
rgb_out  out  12  composited pixel
overlap  out  1  tank bounding boxes intersected on a visible pixel in the last frame

Behaviour:
- Reset (async, rst_n=0): every output 0, all pipeline registers 0, shadow registers 0, tank_en shadow 00, overlap accumulator 0.
- Frame-synchronous shadowing:
  - Rising edge of vblnk_in is detected against a registered copy of vblnk_in.
  - On that cycle, tank*_x/y/dir and tank_en are copied to shadow registers.
  - All hit logic uses only shadows; input changes mid-frame have no effect until the next vblank.
  - After reset nothing is drawn until the first vblank rising edge.
- Hit test per tank i, computed on COORD_W+1 bits (no wrap):
  - hit_i = en_i and hcount >= x_i and hcount < x_i + 2^SPRITE_BITS and the same for vcount/y_i.
  - Sprites partially past coordinate 2^COORD_W-1 are clipped, never wrapped to 0.
- Arbitration:
  - Tank 0 wins when hit0 and hit1 are both true.
  - Owner gets dx = hcount - x, dy = vcount - y, truncated to SPRITE_BITS.
  - Address = {dy, dx}.
- Pipeline, 3 register stages; latency exactly 3 clocks for every output:
  - S1 (edge k): register rom_address, owner dir, hit flag, rgb_in, timing, coordinates. With no hit, rom_address holds its previous value.
  - S2 (edge k+1): ROMs register data; S2 carries dir, hit, rgb, timing.
  - S3 (edge k+2): rgb_out is
    - 0 if hblnk or vblnk (delayed);
    - else the selected ROM colour, if hit and that colour != TRANSPARENT_RGB;
    - else the delayed rgb_in.
  - hcount_out … vblnk_out are the inputs delayed 3 clocks.
- Overlap:
  - A sticky accumulator sets when hit0 and hit1 are both true and not blanking.
  - At the vblnk rising edge, overlap <= accumulator and the accumulator clears in the same cycle. A hit in that same cycle is impossible because it is a blanking cycle.
  - overlap is constant for a whole frame.
- Reset asserted mid-frame clears all stages immediately; no partial pixel is emitted after release. The first valid output appears 3 clocks after the first sampled input.

Test Plan:
- Reset, then one frame with tank_en=11 held: no sprite drawn in frame 0; from frame 1, rgb_out equals rom data in the box only.
- Tank 0 at (100,50), dir=2, ROM2 returns 12'h0A0 at address {6'd3,6'd5}: pixel (105,53) -> rom_address=12'h0C5, rgb_out=12'h0A0 exactly 3 clocks after hcount_in=105.
- Same pixel with ROM data 12'hFFF and rgb_in=12'h123 -> rgb_out=12'h123. During hblnk_in=1 -> rgb_out=0.
- Tank 0 (100,50) and tank 1 (120,60), both enabled: pixel (130,70) uses tank 0's dir and address {6'd20,6'd30}; overlap=1 after the next vblank, 0 one frame after tank 1 moves to (400,300).
- Tank 0 x=2020: hcount 2020..2047 drawn, hcount 0..35 not drawn (no wrap).
- Change tank0_x mid-frame: rendering unchanged until after the vblnk rising edge. Assert rst_n=0 mid-line: all outputs 0 asynchronously, overlap=0.

Source files
------------

// File: rtl/tank_sprite_arbiter.sv
// Two-tank sprite compositor sharing one four-direction image ROM bank.
// Three register stages: address/hit, ROM read, colour select; timing rides alongside.
module tank_sprite_arbiter #(
    parameter int          SPRITE_BITS     = 6,
    parameter logic [11:0] TRANSPARENT_RGB = 12'hFFF,
    parameter int          COORD_W         = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COORD_W-1:0]       hcount_in,
    input  logic [COORD_W-1:0]       vcount_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     hblnk_in,
    input  logic                     vblnk_in,
    input  logic [11:0]              rgb_in,
    input  logic [COORD_W-1:0]       tank0_x,
    input  logic [COORD_W-1:0]       tank0_y,
    input  logic [COORD_W-1:0]       tank1_x,
    input  logic [COORD_W-1:0]       tank1_y,
    input  logic [1:0]               tank0_dir,
    input  logic [1:0]               tank1_dir,
    input  logic [1:0]               tank_en,
    output logic [2*SPRITE_BITS-1:0] rom_address,
    input  logic [11:0]              rom_rgb0,
    input  logic [11:0]              rom_rgb1,
    input  logic [11:0]              rom_rgb2,
    input  logic [11:0]              rom_rgb3,
    output logic [COORD_W-1:0]       hcount_out,
    output logic [COORD_W-1:0]       vcount_out,
    output logic                     hsync_out,
    output logic                     vsync_out,
    output logic                     hblnk_out,
    output logic                     vblnk_out,
    output logic [11:0]              rgb_out,
    output logic                     overlap
);

    localparam int               AW       = 2*SPRITE_BITS;
    localparam logic [COORD_W:0] SPR_SIZE = (COORD_W+1)'(1 << SPRITE_BITS);

    typedef struct packed {
        logic [COORD_W-1:0] hcount;
        logic [COORD_W-1:0] vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
        logic [11:0]        rgb;
    } tim_t;

    typedef struct packed {
        tim_t       t;
        logic [1:0] dir;
        logic       hit;
    } stage_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0, y0, x1, y1;
        logic [1:0]         dir0, dir1, en;
    } shadow_t;

    // One extra bit so a box running past the last coordinate is clipped, not wrapped.
    function automatic logic in_span(input logic [COORD_W-1:0] c, input logic [COORD_W-1:0] o);
        return ({1'b0, c} >= {1'b0, o}) && ({1'b0, c} < ({1'b0, o} + SPR_SIZE));
    endfunction

    logic                   vblnk_q, vblnk_d, vblnk_rise;
    shadow_t                sh_q, sh_d;
    logic                   acc_q, acc_d, overlap_q, overlap_d;
    logic [AW-1:0]          rom_address_q, rom_address_d;
    stage_t                 s1_q, s1_d, s2_q, s2_d;
    tim_t                   s3_q, s3_d;
    logic                   hit0, hit1;
    logic [SPRITE_BITS-1:0] dx0, dy0, dx1, dy1;
    logic [11:0]            rom_sel;

    always_comb begin
        vblnk_d    = vblnk_in;
        vblnk_rise = vblnk_in & ~vblnk_q;

        sh_d = sh_q;
        if (vblnk_rise)
            sh_d = '{tank0_x, tank0_y, tank1_x, tank1_y, tank0_dir, tank1_dir, tank_en};

        hit0 = sh_q.en[0] && in_span(hcount_in, sh_q.x0) && in_span(vcount_in, sh_q.y0);
        hit1 = sh_q.en[1] && in_span(hcount_in, sh_q.x1) && in_span(vcount_in, sh_q.y1);
        dx0  = SPRITE_BITS'(hcount_in - sh_q.x0);
        dy0  = SPRITE_BITS'(vcount_in - sh_q.y0);
        dx1  = SPRITE_BITS'(hcount_in - sh_q.x1);
        dy1  = SPRITE_BITS'(vcount_in - sh_q.y1);

        // Tank 0 owns contested pixels; the address is left alone on misses.
        rom_address_d = rom_address_q;
        if (hit0)      rom_address_d = {dy0, dx0};
        else if (hit1) rom_address_d = {dy1, dx1};

        s1_d.t   = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
        s1_d.dir = hit0 ? sh_q.dir0 : sh_q.dir1;
        s1_d.hit = hit0 | hit1;

        s2_d = s1_q;

        rom_sel = rom_rgb0;
        case (s2_q.dir)
            2'd1:    rom_sel = rom_rgb1;
            2'd2:    rom_sel = rom_rgb2;
            2'd3:    rom_sel = rom_rgb3;
            default: rom_sel = rom_rgb0;
        endcase

        s3_d = s2_q.t;
        if (s2_q.t.hblnk || s2_q.t.vblnk)                s3_d.rgb = 12'h000;
        else if (s2_q.hit && rom_sel != TRANSPARENT_RGB) s3_d.rgb = rom_sel;

        // Accumulate during the frame, publish and restart at vblank onset.
        acc_d     = acc_q;
        overlap_d = overlap_q;
        if (vblnk_rise) begin
            overlap_d = acc_q;
            acc_d     = 1'b0;
        end else if (hit0 && hit1 && !hblnk_in && !vblnk_in) begin
            acc_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q       <= 1'b0;
            sh_q          <= '0;
            acc_q         <= 1'b0;
            overlap_q     <= 1'b0;
            rom_address_q <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
        end else begin
            vblnk_q       <= vblnk_d;
            sh_q          <= sh_d;
            acc_q         <= acc_d;
            overlap_q     <= overlap_d;
            rom_address_q <= rom_address_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
        end
    end

    assign rom_address = rom_address_q;
    assign overlap     = overlap_q;
    assign hcount_out  = s3_q.hcount;
    assign vcount_out  = s3_q.vcount;
    assign hsync_out   = s3_q.hsync;
    assign vsync_out   = s3_q.vsync;
    assign hblnk_out   = s3_q.hblnk;
    assign vblnk_out   = s3_q.vblnk;
    assign rgb_out     = s3_q.rgb;

endmodule

// File: tb/tb_tank_sprite_arbiter.sv
// Bench for tank_sprite_arbiter: table of pixels plus hand sequences for vblank,
// overlap, clipping and reset; pixel results are scoreboarded 3 clocks after drive.
module tb_tank_sprite_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in, tank0_x, tank0_y, tank1_x, tank1_y;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [1:0]  tank0_dir, tank1_dir, tank_en;
    logic [11:0] rom_address;
    logic [11:0] rom_rgb0, rom_rgb1, rom_rgb2, rom_rgb3;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out, overlap;
    logic [11:0] rgb_out;
    logic [11:0] rom_special;

    always #5 clk = ~clk;

    tank_sprite_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
        .tank0_dir(tank0_dir), .tank1_dir(tank1_dir), .tank_en(tank_en),
        .rom_address(rom_address),
        .rom_rgb0(rom_rgb0), .rom_rgb1(rom_rgb1), .rom_rgb2(rom_rgb2), .rom_rgb3(rom_rgb3),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .overlap(overlap)
    );

    // ROM image: direction in the top two bits, low address bits below; one cell overridable.
    function automatic logic [11:0] rom_fn(input logic [1:0] d, input logic [11:0] a);
        if (d == 2'd2 && a == 12'h0C5) return rom_special;
        return {d, a[9:0]};
    endfunction

    always @(posedge clk) begin
        rom_rgb0 <= rom_fn(2'd0, rom_address);
        rom_rgb1 <= rom_fn(2'd1, rom_address);
        rom_rgb2 <= rom_fn(2'd2, rom_address);
        rom_rgb3 <= rom_fn(2'd3, rom_address);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [10:0] h, v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
        int          id;
    } exp_t;

    typedef struct {
        logic [10:0] h, v;
        logic        hb;
        logic [11:0] rgb, ex;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [63:0] all_outs();
        return {13'b0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                rgb_out, overlap, rom_address};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, ex);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                         input logic [11:0] rgb, input logic [11:0] ex, input int id);
        exp_t e;
        @(posedge clk); #1;
        hcount_in = h;   vcount_in = v;
        hsync_in  = h[1]; vsync_in = v[1];
        hblnk_in  = hb;  vblnk_in  = vb;
        rgb_in    = rgb;
        e.due = cyc + 3; e.h = h; e.v = v; e.hs = h[1]; e.vs = v[1];
        e.hb = hb; e.vb = vb; e.rgb = ex; e.id = id;
        sb_q.push_back(e);
    endtask

    task automatic vblank();
        repeat (3) drive(11'd0, 11'd0, 1'b1, 1'b1, 12'hABC, 12'h000, 900);
        drive(11'd0, 11'd0, 1'b1, 1'b0, 12'hABC, 12'h000, 901);
    endtask

    task automatic chk_addr(input string nm, input logic [11:0] ex);
        @(posedge clk); #2;
        chk(nm, 64'(rom_address), 64'(ex));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
        tank0_x = '0; tank0_y = '0; tank1_x = '0; tank1_y = '0;
        tank0_dir = '0; tank1_dir = '0; tank_en = '0;
        rom_special = 12'h0A0;

        vecs[0]  = '{11'd105, 11'd53,  1'b0, 12'h123, 12'h0A0};
        vecs[1]  = '{11'd130, 11'd70,  1'b0, 12'h456, 12'h91E};
        vecs[2]  = '{11'd99,  11'd53,  1'b0, 12'h777, 12'h777};
        vecs[3]  = '{11'd164, 11'd53,  1'b0, 12'h778, 12'h778};
        vecs[4]  = '{11'd170, 11'd80,  1'b0, 12'h779, 12'h532};
        vecs[5]  = '{11'd183, 11'd123, 1'b0, 12'h77A, 12'h7FF};
        vecs[6]  = '{11'd184, 11'd123, 1'b0, 12'h77B, 12'h77B};
        vecs[7]  = '{11'd130, 11'd70,  1'b1, 12'h456, 12'h000};
        vecs[8]  = '{11'd113, 11'd113, 1'b0, 12'h77C, 12'hBCD};
        vecs[9]  = '{11'd0,   11'd0,   1'b0, 12'h77D, 12'h77D};
        vecs[10] = '{11'd100, 11'd50,  1'b0, 12'h77E, 12'h800};
        vecs[11] = '{11'd120, 11'd60,  1'b0, 12'h77F, 12'hA94};

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (e.due != cyc || hcount_out !== e.h || vcount_out !== e.v ||
                        hsync_out !== e.hs || vsync_out !== e.vs || hblnk_out !== e.hb ||
                        vblnk_out !== e.vb || rgb_out !== e.rgb) begin
                        failures++;
                        $display("FAIL pix id=%0d cyc=%0d got h=%0d v=%0d s=%b%b b=%b%b rgb=%h exp h=%0d v=%0d s=%b%b b=%b%b rgb=%h due=%0d",
                                 e.id, cyc, hcount_out, vcount_out, hsync_out, vsync_out,
                                 hblnk_out, vblnk_out, rgb_out, e.h, e.v, e.hs, e.vs,
                                 e.hb, e.vb, e.rgb, e.due);
                    end
                end
            end
        join_none

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 chk("reset_state", all_outs(), 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // Frame 0: configuration presented but not yet shadowed.
        tank0_x = 11'd100; tank0_y = 11'd50;  tank0_dir = 2'd2;
        tank1_x = 11'd120; tank1_y = 11'd60;  tank1_dir = 2'd1;
        tank_en = 2'b11;
        drive(11'd105, 11'd53, 1'b0, 1'b0, 12'h123, 12'h123, 100);
        drive(11'd130, 11'd70, 1'b0, 1'b0, 12'h456, 12'h456, 101);
        vblank();

        for (int i = 0; i < 12; i++)
            drive(vecs[i].h, vecs[i].v, vecs[i].hb, 1'b0, vecs[i].rgb, vecs[i].ex, i);

        drive(11'd105, 11'd53, 1'b0, 1'b0, 12'h123, 12'h0A0, 200);
        chk_addr("addr_hit", 12'h0C5);
        drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h111, 12'h111, 201);
        chk_addr("addr_hold", 12'h0C5);
        chk("ovl_frame1", 64'(overlap), 64'd0);
        vblank();
        chk("ovl_set", 64'(overlap), 64'd1);

        // Mid-frame moves stay invisible until the next vblank.
        tank0_x = 11'd500; tank1_x = 11'd400; tank1_y = 11'd300;
        drive(11'd105, 11'd53, 1'b0, 1'b0, 12'h123, 12'h0A0, 300);
        drive(11'd130, 11'd70, 1'b0, 1'b0, 12'h456, 12'h91E, 301);
        chk("ovl_hold_frame", 64'(overlap), 64'd1);
        vblank();
        chk("ovl_old_shadow", 64'(overlap), 64'd1);
        drive(11'd105, 11'd53, 1'b0, 1'b0, 12'h123, 12'h123, 302);
        drive(11'd505, 11'd53, 1'b0, 1'b0, 12'h123, 12'h0A0, 303);
        vblank();
        chk("ovl_clear", 64'(overlap), 64'd0);

        rom_special = 12'hFFF;
        drive(11'd505, 11'd53, 1'b0, 1'b0, 12'h123, 12'h123, 400);
        drive(11'd505, 11'd53, 1'b1, 1'b0, 12'h123, 12'h000, 401);

        tank0_x = 11'd2020;
        vblank();
        drive(11'd2020, 11'd53, 1'b0, 1'b0, 12'h555, 12'h8C0, 500);
        drive(11'd2047, 11'd53, 1'b0, 1'b0, 12'h555, 12'h8DB, 501);
        drive(11'd0,    11'd53, 1'b0, 1'b0, 12'h555, 12'h555, 502);
        drive(11'd35,   11'd53, 1'b0, 1'b0, 12'h555, 12'h555, 503);
        drive(11'd2019, 11'd53, 1'b0, 1'b0, 12'h555, 12'h555, 504);

        repeat (4) drive(11'd2020, 11'd53, 1'b0, 1'b0, 12'h555, 12'h8C0, 600);
        @(posedge clk); #1;
        sb_q.delete();
        rst_n = 1'b0;
        #1 chk("reset_midline", all_outs(), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Shadows were cleared, so nothing draws until another vblank.
        drive(11'd2020, 11'd53, 1'b0, 1'b0, 12'h321, 12'h321, 700);
        drive(11'd105,  11'd53, 1'b0, 1'b0, 12'h654, 12'h654, 701);

        repeat (6) @(posedge clk);
        #2 chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
